// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state/redirect encodings and default vectors for pc_sequencer.
package pc_sequencer_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_RET, RD_BR, RD_TRAP} redir_t;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
    function automatic redir_t redir_sel(logic trap, logic br, logic ret);
        return trap ? RD_TRAP : br ? RD_BR : ret ? RD_RET : RD_NONE;
    endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] sp, sp_inc, sp_dec;
    logic [CW-1:0] cnt;
    assign sp_inc = sp == LAST ? '0 : sp + 1'b1;
    assign sp_dec = sp == '0 ? LAST : sp - 1'b1;
    assign top = mem[sp_dec];
    assign empty = cnt == '0;
    assign full = cnt == CW'(RAS_DEPTH);
    // the count saturates so a wrapped push keeps full asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            cnt <= '0;
        end else if (push) begin
            sp <= sp_inc;
            cnt <= full ? cnt : cnt + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_dec;
            cnt <= cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[sp] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: BOOT/RUN/HALT program-counter sequencer with trap/branch/return redirects.
// Define PC_SEQUENCER_RAS_EN to include the return-address stack (pc_ras).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int INC = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            trap_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam logic [XLEN-1:0] STEP = XLEN'(INC);
    localparam logic [XLEN-1:0] MASK = ~(STEP - 1'b1);
    state_t state, state_next;
    redir_t sel;
    logic [XLEN-1:0] seq_pc, target, pc_next, ras_top;
    logic ret_ok, hs;
`ifdef PC_SEQUENCER_RAS_EN
    pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .rst_n(rst_n),
        .push(sel == RD_BR && call_i),
        .pop(sel == RD_RET),
        .push_data(seq_pc),
        .top(ras_top),
        .empty(ras_empty),
        .full(ras_full)
    );
    assign ret_ok = ret_i & ~ras_empty;
`else
    logic unused_ras;
    assign unused_ras = call_i ^ ret_i;
    assign ras_top = '0;
    assign ras_empty = 1'b1;
    assign ras_full = 1'b0;
    assign ret_ok = 1'b0;
`endif
    assign sel = redir_sel(trap_i, br_taken, ret_ok);
    assign seq_pc = pc_o + STEP;
    assign hs = pc_valid & fetch_ready & ~stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: state_next = halt_i ? HALT : RUN;
            HALT: state_next = (resume_i || trap_i) ? RUN : HALT;
            default: state_next = BOOT;
        endcase
    end
    always_comb begin
        pc_valid = state == RUN;
    end
    always_comb begin
        target = (sel == RD_TRAP ? TRAP_VEC : sel == RD_BR ? br_target : ras_top) & MASK;
        pc_next = sel != RD_NONE ? target : hs ? seq_pc : pc_o;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_o <= RESET_VEC;
        else pc_o <= pc_next;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (both PC_SEQUENCER_RAS_EN builds).
module tb_pc_sequencer;
`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam logic [7:0] FR = 8'h80, ST = 8'h40, BR = 8'h20, CL = 8'h10;
    localparam logic [7:0] RT = 8'h08, TR = 8'h04, HL = 8'h02, RS = 8'h01;
    typedef struct {
        logic [31:0] pc;
        logic v, e, f;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_ready = 0, stall = 0, br_taken = 0, call_i = 0, ret_i = 0;
    logic trap_i = 0, halt_i = 0, resume_i = 0;
    logic [31:0] br_target = '0;
    logic [31:0] pc_o;
    logic pc_valid, ras_empty, ras_full;
    int tests = 0, fails = 0;
    exp_t sb[$];
    logic [31:0] m_stk[$];
    logic [31:0] m_pc = 32'h0;
    int m_state = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .call_i(call_i), .ret_i(ret_i),
        .trap_i(trap_i), .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc_o),
        .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: computes the state after the next edge and queues it
    task automatic drive(input logic [7:0] c, input logic [31:0] tgt);
        logic rret;
        logic [31:0] nxt;
        exp_t e;
        {fetch_ready, stall, br_taken, call_i, ret_i, trap_i, halt_i, resume_i} = c;
        br_target = tgt;
        rret = RAS && c[3] && m_stk.size() > 0;
        nxt = m_pc;
        if (m_state == 1 && c[7] && !c[6]) nxt = m_pc + 32'd4;
        if (c[2]) nxt = 32'h100;
        else if (c[5]) nxt = tgt & ~32'h3;
        else if (rret) nxt = m_stk[$] & ~32'h3;
        if (RAS && !c[2] && c[5] && c[4]) begin
            m_stk.push_back(m_pc + 32'd4);
            if (m_stk.size() > 4) void'(m_stk.pop_front());
        end else if (!c[2] && !c[5] && rret) void'(m_stk.pop_back());
        m_pc = nxt;
        m_state = m_state == 0 ? 1 : m_state == 1 ? (c[1] ? 2 : 1) : ((c[0] || c[2]) ? 1 : 2);
        e.pc = m_pc;
        e.v = m_state == 1;
        e.e = m_stk.size() == 0;
        e.f = m_stk.size() == 4;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input logic [7:0] c, input logic [31:0] tgt);
        exp_t e;
        drive(c, tgt);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_pc"}, pc_o, e.pc);
        chk({tag, "_valid"}, {31'b0, pc_valid}, {31'b0, e.v});
        chk({tag, "_empty"}, {31'b0, ras_empty}, {31'b0, e.e});
        chk({tag, "_full"}, {31'b0, ras_full}, {31'b0, e.f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("boot_valid", {31'b0, pc_valid}, 32'h0);
        step("boot", FR, 0);
        chk("run_pc0", pc_o, 32'h0);
        step("seq4", FR, 0);
        step("seq8", FR, 0);
        step("seq12", FR, 0);
        chk("seq_end", pc_o, 32'd12);
        step("stall", FR | ST, 0);
        chk("stall_hold", pc_o, 32'd12);
        step("br_align", FR | ST | BR, 32'h1003);
        chk("br_target", pc_o, 32'h1000);
        step("prio", FR | BR | RT | TR, 32'h2000);
        chk("prio_trap", pc_o, 32'h100);
        step("to20", FR | BR, 32'h20);
        step("call", FR | BR | CL, 32'h400);
        chk("call_pc", pc_o, 32'h400);
        chk("call_empty", {31'b0, ras_empty}, RAS ? 32'h0 : 32'h1);
        step("ret", FR | RT, 0);
        chk("ret_pc", pc_o, RAS ? 32'h24 : 32'h404);
        step("ret_empty", FR | RT, 0);
        chk("ret_empty_pc", pc_o, RAS ? 32'h28 : 32'h408);
        for (int k = 0; k < 5; k++) step("deep_call", FR | BR | CL, 32'h1000 + 32'(k) * 32'h100);
        chk("deep_full", {31'b0, ras_full}, {31'b0, RAS});
        step("deep_ret0", FR | RT, 0);
        chk("lifo_first", pc_o, RAS ? 32'h1304 : 32'h1404);
        for (int k = 1; k < 4; k++) step("deep_ret", FR | RT, 0);
        chk("lifo_last", pc_o, RAS ? 32'h1004 : 32'h1410);
        step("to_top", FR | BR, 32'hFFFF_FFFC);
        step("wrap", FR, 0);
        chk("wrap_pc", pc_o, 32'h0);
        step("halt", FR | HL, 0);
        chk("halt_valid", {31'b0, pc_valid}, 32'h0);
        step("halt_br", FR | BR, 32'h300);
        step("resume", FR | RS, 0);
        step("resume_run", FR | RS, 0);
        step("br_halt", FR | BR | HL, 32'h500);
        step("halt_in_halt", FR | HL, 0);
        step("trap_exit", FR | TR, 0);
        step("trap_halt", FR | TR | HL, 0);
        chk("trap_halt_pc", pc_o, 32'h100);
        step("halt_call", FR | BR | CL, 32'h800);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("mid_rst_full", {31'b0, ras_full}, 32'h0);
        m_state = 0;
        m_pc = 32'h0;
        m_stk.delete();
        #2;
        rst_n = 1'b1;
        step("reboot", FR, 0);
        step("ret_after_rst", FR | RT, 0);
        chk("rst_discard", pc_o, 32'h4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
